// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          BYTE_W    = 8;

    // Storage returns byte a in [31:24]; little-endian instances reverse the lanes.
    function automatic logic [31:0] order_bytes(input logic [31:0] be_word, input bit big_endian);
        return big_endian ? be_word
                          : {be_word[7:0], be_word[15:8], be_word[23:16], be_word[31:24]};
    endfunction

endpackage

// File: rtl/instr_memory_loadable_if.sv
// Load stream, fetch request/response and status signals of the instruction memory.
interface instr_memory_loadable_if #(parameter int ADDR_W = 6);
    import imem_pkg::*;

    // Handshakes: a load byte transfers on a cycle with load_valid && load_ready, a fetch
    // on a cycle with fetch_req && fetch_ready; rsp_valid pulses one cycle after each fetch.
    logic              load_start;
    logic              load_valid;
    logic [BYTE_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_instr;
    logic              rsp_fault;
    logic [ADDR_W:0]   prog_len;
    logic              mem_ready;
    imem_state_e       state;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, fetch_ready, rsp_valid, rsp_instr, rsp_fault, prog_len,
               mem_ready, state
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, fetch_ready, rsp_valid, rsp_instr, rsp_fault, prog_len,
               mem_ready, state
    );

endinterface

// File: rtl/imem_byte_array.sv
// Byte-wide program storage: one write port, one registered 4-byte read port.
module imem_byte_array
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [BYTE_W-1:0] mem [DEPTH_BYTES];

    // Contents are deliberately not reset so a program survives a reset or reload.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Callers only read words that lie fully inside the loaded image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= {mem[raddr],
                      mem[raddr + ADDR_W'(1)],
                      mem[raddr + ADDR_W'(2)],
                      mem[raddr + ADDR_W'(3)]};
        end
    end

endmodule

// File: rtl/instr_memory_loadable.sv
// Instruction memory loaded by a byte stream, fetched as aligned 32-bit words.
module instr_memory_loadable
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16,
    parameter int BIG_ENDIAN  = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    instr_memory_loadable_if.slave   bus
);

    localparam int DEPTH_BYTES = 4 * DEPTH_WORDS;
    localparam int ADDR_W      = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] DEPTH_LEN  = (ADDR_W + 1)'(DEPTH_BYTES);
    localparam logic [ADDR_W:0] WORD_BYTES = (ADDR_W + 1)'(4);

    imem_state_e     state, state_nxt;
    logic [ADDR_W:0] ptr, ptr_nxt;
    logic [ADDR_W:0] len_q, len_nxt;
    logic            load_ready_int;
    logic            load_acc;
    logic            fetch_ready_int;
    logic            fetch_acc;
    logic            fetch_fault;
    logic            rsp_valid_q;
    logic            fault_q;
    logic [31:0]     rdata;

    assign load_ready_int  = (state == ST_LOADING) && (ptr < DEPTH_LEN);
    assign load_acc        = bus.load_valid && load_ready_int;
    assign fetch_ready_int = (state == ST_READY) && !bus.load_start;
    assign fetch_acc       = bus.fetch_req && fetch_ready_int;

    // Extra bit on the range check keeps addr+4 from wrapping near the top of memory.
    assign fetch_fault = (bus.fetch_addr[1:0] != 2'b00) ||
                         (({1'b0, bus.fetch_addr} + WORD_BYTES) > len_q);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        len_nxt   = len_q;
        case (state)
            ST_LOADING: begin
                if (load_acc) begin
                    ptr_nxt = ptr + 1'b1;
                    if (bus.load_last || (ptr_nxt == DEPTH_LEN)) begin
                        state_nxt = ST_READY;
                        len_nxt   = ptr_nxt;
                    end
                end
            end
            default: ;
        endcase
        // A new load overrides whatever else happens this cycle.
        if (bus.load_start) begin
            state_nxt = ST_LOADING;
            ptr_nxt   = '0;
            len_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            ptr   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            len_q <= len_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            rsp_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fault_q <= fetch_fault;
            end
        end
    end

    imem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (load_acc),
        .waddr (ptr[ADDR_W-1:0]),
        .wdata (bus.load_data),
        .re    (fetch_acc && !fetch_fault),
        .raddr (bus.fetch_addr),
        .rdata (rdata)
    );

    assign bus.load_ready  = load_ready_int;
    assign bus.fetch_ready = fetch_ready_int;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_instr   = fault_q ? NOP_INSTR : order_bytes(rdata, BIG_ENDIAN != 0);
    assign bus.rsp_fault   = fault_q;
    assign bus.prog_len    = len_q;
    assign bus.mem_ready   = (state == ST_READY);
    assign bus.state       = state;

endmodule

// File: tb/tb_instr_memory_loadable.sv
// Randomized scoreboard bench for instr_memory_loadable (64-byte big-endian and 8-byte little-endian instances).
module tb_instr_memory_loadable;
  import imem_pkg::*;

  localparam int DEPTH_A = 64;
  localparam int AW_A    = 6;
  localparam int AW_B    = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_memory_loadable_if #(.ADDR_W(AW_A)) bus_a ();
  instr_memory_loadable_if #(.ADDR_W(AW_B)) bus_b ();

  instr_memory_loadable #(.DEPTH_WORDS(16), .BIG_ENDIAN(1)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  instr_memory_loadable #(.DEPTH_WORDS(2), .BIG_ENDIAN(0)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instance A) ----------------
  logic [7:0] m_mem [DEPTH_A];
  int         m_len;
  int         m_ptr;
  bit         m_loading;
  bit         m_ready;

  function automatic logic [32:0] model_rsp(input int a);
    if ((a % 4) != 0 || (a + 4) > m_len) return {1'b1, 32'h0};
    return {1'b0, m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]};
  endfunction

  task automatic model_reset();
    m_len = 0; m_ptr = 0; m_loading = 0; m_ready = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  logic        stage_v = 1'b0;
  logic [32:0] stage_d = '0;
  logic [32:0] last_rsp = '0;
  logic [32:0] mon_e;

  always @(posedge clk) begin
    if (rst_n && stage_v) exp_q.push_back(stage_d);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_rsp = '0;
    end else if (bus_a.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rsp_unexpected: rsp_valid 1 got instr %h, required no response", bus_a.rsp_instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_instr", 64'(bus_a.rsp_instr), 64'(mon_e[31:0]));
        chk("rsp_fault", 64'(bus_a.rsp_fault), 64'(mon_e[32]));
        last_rsp = mon_e;
      end
    end else if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_vec++; n_err++;
      $display("FAIL rsp_missing: rsp_valid 0, required response %h", mon_e);
    end else begin
      chk("rsp_hold_instr", 64'(bus_a.rsp_instr), 64'(last_rsp[31:0]));
      chk("rsp_hold_fault", 64'(bus_a.rsp_fault), 64'(last_rsp[32]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    bus_a.load_start = 0; bus_a.load_valid = 0; bus_a.load_data = '0;
    bus_a.load_last = 0; bus_a.fetch_req = 0; bus_a.fetch_addr = '0;
  endtask

  task automatic idle_b();
    bus_b.load_start = 0; bus_b.load_valid = 0; bus_b.load_data = '0;
    bus_b.load_last = 0; bus_b.fetch_req = 0; bus_b.fetch_addr = '0;
  endtask

  // Drives one cycle on instance A, checks handshake/status, updates the model.
  task automatic drive_a(input bit ls, input bit lv, input logic [7:0] ld, input bit ll,
                         input bit fr, input int fa);
    bit acc_l;
    bus_a.load_start = ls; bus_a.load_valid = lv; bus_a.load_data = ld;
    bus_a.load_last = ll; bus_a.fetch_req = fr; bus_a.fetch_addr = AW_A'(fa);
    #1;
    chk("load_ready",  64'(bus_a.load_ready),  64'(m_loading && m_ptr < DEPTH_A));
    chk("fetch_ready", 64'(bus_a.fetch_ready), 64'(m_ready && !ls));
    chk("mem_ready",   64'(bus_a.mem_ready),   64'(m_ready));
    chk("prog_len",    64'(bus_a.prog_len),    64'(m_len));
    stage_v = fr && m_ready && !ls;
    stage_d = model_rsp(fa);
    acc_l = lv && m_loading && m_ptr < DEPTH_A;
    if (acc_l) begin
      m_mem[m_ptr] = ld;
      m_ptr++;
      if (ll || m_ptr == DEPTH_A) begin
        m_loading = 0; m_ready = 1; m_len = m_ptr;
      end
    end
    if (ls) begin
      m_loading = 1; m_ready = 0; m_ptr = 0; m_len = 0;
    end
    @(posedge clk); #1;
    stage_v = 0;
    idle_a();
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_state"},       64'(bus_a.state),       64'(ST_EMPTY));
    chk({tag, "_load_ready"},  64'(bus_a.load_ready),  64'(0));
    chk({tag, "_fetch_ready"}, 64'(bus_a.fetch_ready), 64'(0));
    chk({tag, "_mem_ready"},   64'(bus_a.mem_ready),   64'(0));
    chk({tag, "_prog_len"},    64'(bus_a.prog_len),    64'(0));
    chk({tag, "_rsp_valid"},   64'(bus_a.rsp_valid),   64'(0));
    chk({tag, "_rsp_instr"},   64'(bus_a.rsp_instr),   64'(0));
    chk({tag, "_rsp_fault"},   64'(bus_a.rsp_fault),   64'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] prog8 [8] = '{8'h8D, 8'h09, 8'h00, 8'h00, 8'h8D, 8'h0A, 8'h00, 8'h04};
  logic [7:0] bb [9];

  initial begin
    int n;
    idle_a(); idle_b(); model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_reset_a("reset");
    chk("b_reset_prog_len", 64'(bus_b.prog_len), 64'(0));
    chk("b_reset_rsp_valid", 64'(bus_b.rsp_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch before any load must be refused.
    repeat (3) drive_a(0, 0, 8'h00, 0, 1, 0);

    // Directed program: two words, fetched back-to-back, then faulting fetches.
    drive_a(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive_a(0, 1, prog8[i], i == 7, 0, 0);
    drive_a(0, 0, 8'h00, 0, 1, 0);
    drive_a(0, 0, 8'h00, 0, 1, 4);
    drive_a(0, 0, 8'h00, 0, 1, 2);
    drive_a(0, 0, 8'h00, 0, 1, 8);
    drive_a(0, 0, 8'h00, 0, 0, 0);
    drive_a(0, 0, 8'h00, 0, 0, 0);

    // load_start wins over a same-cycle fetch.
    drive_a(1, 0, 8'h00, 0, 1, 0);
    chk("start_wins_state", 64'(bus_a.state), 64'(ST_LOADING));

    // Randomized load / fetch rounds.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 72);
      drive_a(1, 0, 8'h00, 0, 0, 0);
      for (int k = 0; k < 400 && m_loading; k++) begin
        drive_a(0, $urandom_range(0, 3) != 0, 8'($urandom), m_ptr == n - 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 63));
      end
      for (int k = 0; k < 40; k++) begin
        int fa;
        fa = $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0) fa = fa & ~3;
        drive_a($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, fa);
      end
    end

    // Reset in the middle of a load.
    drive_a(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_a(0, 1, 8'($urandom), 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_a("midload_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) drive_a(0, 0, 8'h00, 0, 1, 0);

    // New load, then reset with a fetch response in flight.
    drive_a(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive_a(0, 1, 8'($urandom), i == 11, 0, 0);
    drive_a(0, 0, 8'h00, 0, 1, 4);
    drive_a(0, 0, 8'h00, 0, 1, 8);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_a("midfetch_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) drive_a(0, 0, 8'h00, 0, 1, 0);

    // Instance B: 8-byte store, little-endian, 9 bytes streamed with no load_last.
    for (int i = 0; i < 9; i++) bb[i] = 8'($urandom);
    bus_b.load_start = 1; @(posedge clk); #1; idle_b();
    for (int i = 0; i < 9; i++) begin
      bus_b.load_valid = 1; bus_b.load_data = bb[i];
      #1;
      chk("b_load_ready", 64'(bus_b.load_ready), 64'(i < 8));
      @(posedge clk); #1;
    end
    idle_b(); #1;
    chk("b_mem_ready",  64'(bus_b.mem_ready),  64'(1));
    chk("b_prog_len",   64'(bus_b.prog_len),   64'(8));
    chk("b_load_ready_full", 64'(bus_b.load_ready), 64'(0));
    bus_b.fetch_req = 1; bus_b.fetch_addr = 3'd0; @(posedge clk); #1;
    chk("b_rsp_valid0", 64'(bus_b.rsp_valid), 64'(1));
    chk("b_rsp_instr0", 64'(bus_b.rsp_instr), 64'({bb[3], bb[2], bb[1], bb[0]}));
    bus_b.fetch_addr = 3'd4; @(posedge clk); #1;
    chk("b_rsp_instr4", 64'(bus_b.rsp_instr), 64'({bb[7], bb[6], bb[5], bb[4]}));
    chk("b_rsp_fault4", 64'(bus_b.rsp_fault), 64'(0));
    bus_b.fetch_addr = 3'd5; @(posedge clk); #1;
    chk("b_rsp_instr5", 64'(bus_b.rsp_instr), 64'(0));
    chk("b_rsp_fault5", 64'(bus_b.rsp_fault), 64'(1));
    idle_b(); @(posedge clk); #1;
    chk("b_rsp_valid_idle", 64'(bus_b.rsp_valid), 64'(0));
    chk("b_rsp_fault_hold", 64'(bus_b.rsp_fault), 64'(1));

    repeat (2) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_memory_loadable.md
INSTR_MEMORY_LOADABLE -- requirements
Module: instr_memory_loadable

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16: storage depth in 32-bit words, ≥2.
REQ-002 SHALL have parameter BIG_ENDIAN, default 1: byte order of a fetched word. 1 = byte a in [31:24]; 0 = byte a in [7:0].
REQ-003 SHALL derive localparam DEPTH_BYTES = 4*DEPTH_WORDS and ADDR_W = clog2(DEPTH_BYTES).
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port load_start, input, 1: pulse that begins a new program load.
REQ-007 Port load_valid, input, 1: a load byte is present.
REQ-008 Port load_data, input, 8: the load byte.
REQ-009 Port load_last, input, 1: qualifies the final byte of the load.
REQ-010 Port load_ready, output, 1: a load byte is accepted when load_valid and load_ready are both high.
REQ-011 Port fetch_req, input, 1: fetch request.
REQ-012 Port fetch_addr, input, ADDR_W: fetch byte address.
REQ-013 Port fetch_ready, output, 1: a fetch is accepted when fetch_req and fetch_ready are both high.
REQ-014 Port rsp_valid, output, 1: a fetch response is present.
REQ-015 Port rsp_instr, output, 32: the fetched instruction.
REQ-016 Port rsp_fault, output, 1: the fetch was misaligned or out of range.
REQ-017 Port prog_len, output, ADDR_W+1: number of bytes loaded.
REQ-018 Port mem_ready, output, 1: high when state is READY.

Function
REQ-019 FSM states: EMPTY, LOADING, READY. Reset state SHALL be EMPTY.
REQ-020 load_start in any state SHALL give next state LOADING, with write pointer 0, prog_len 0 and rsp_valid 0.
REQ-021 In LOADING, load_ready SHALL be 1 while pointer < DEPTH_BYTES; an accepted byte SHALL be written to byte[pointer], and pointer SHALL increment by 1.
REQ-022 An accepted byte with load_last SHALL move the FSM to READY next cycle, with prog_len = pointer+1.
REQ-023 When the pointer reaches DEPTH_BYTES without load_last, the FSM SHALL move to READY with prog_len = DEPTH_BYTES. Further bytes SHALL be refused (load_ready 0).
REQ-024 In EMPTY and READY, load_ready SHALL be 0.
REQ-025 fetch_ready SHALL be combinational: (state == READY) and not load_start. A same-cycle load_start therefore wins over fetch_req.
REQ-026 An accepted fetch SHALL produce rsp_valid = 1 exactly one cycle later (latency 1), with one accepted fetch per cycle sustainable.
REQ-027 Fault condition: fetch_addr[1:0] ≠ 0, or fetch_addr+4 > prog_len. On a fault, rsp_instr SHALL be 32'h0 (NOP) and rsp_fault SHALL be 1. The range comparison SHALL use ADDR_W+1 bits so it does not wrap.
REQ-028 Without a fault, rsp_instr SHALL be bytes a..a+3 ordered per BIG_ENDIAN, and rsp_fault SHALL be 0.
REQ-029 A cycle with no accepted fetch SHALL give rsp_valid 0. rsp_instr and rsp_fault SHALL hold their last values.
REQ-030 Memory contents SHALL persist across load_start. Bytes at or beyond prog_len SHALL be unreachable through a fetch.

Reset
REQ-031 With rst_n low, immediately and independent of clk:
- state EMPTY, pointer 0
- prog_len 0
- load_ready 0, fetch_ready 0, mem_ready 0
- rsp_valid 0, rsp_instr 0, rsp_fault 0
REQ-032 Reset mid-load or mid-fetch SHALL abandon the operation; no response SHALL be emitted after reset.
REQ-033 The storage array SHALL NOT be reset.

Structure
REQ-034 Package imem_pkg SHALL hold the FSM state enum, constant NOP_INSTR = 32'h0, and BYTE_W = 8.
REQ-035 Storage SHALL be one sub-module, imem_byte_array: byte-wide, one write port, one registered 4-byte read port.
REQ-036 The FSM, pointer and fault logic SHALL reside in the top module.

Verification
REQ-037 Reset, then fetch_req=1, fetch_addr=0 -> fetch_ready 0; rsp_valid stays 0.
REQ-038 load_start, then bytes 8D 09 00 00 8D 0A 00 04 with load_last on the 8th -> mem_ready 1, prog_len 8. Fetch 0 then 4 back-to-back -> rsp 0x8D090000 then 0x8D0A0004 on consecutive cycles, fault 0.
REQ-039 After REQ-038, fetch 2 -> rsp 0x0 with fault 1. Fetch 8 -> rsp 0x0 with fault 1.
REQ-040 DEPTH_WORDS=2, stream 9 bytes without load_last -> READY after the 8th byte, prog_len 8, load_ready 0, 9th byte not written.
REQ-041 In READY, load_start and fetch_req in the same cycle -> fetch not accepted, rsp_valid 0, state LOADING.
REQ-042 rst_n low after 3 load bytes -> outputs zero at once. After release, fetch_ready 0 until a new load completes.
